// File: rtl/alu_md_pkg.sv
// Shared encodings for the multi-cycle ALU: operation codes, FSM states and
// the helper that separates iterative ops from single-cycle ones.
package alu_md_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_LUI  = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_MULU = 5'b10000;
    localparam logic [4:0] OP_MUL  = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10010;
    localparam logic [4:0] OP_DIV  = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Codes 10000..10011 run through the iterative core; everything else is 1-cycle.
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/alu_md_core.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with sign fix-up applied on output.
module md_core
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             go,
    input  logic             calc,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_dz
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi, lo, m, a_r;
    logic [SHW-1:0]   cnt;
    logic             div_r, neg_lo, neg_hi, dz_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, shifted, sub_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // hi is product-high / partial remainder, lo is multiplier / dividend-quotient.
    assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign shifted  = {hi, lo[WIDTH-1]};
    assign sub_diff = shifted - {1'b0, m};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            a_r    <= '0;
            cnt    <= '0;
            div_r  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz_r   <= 1'b0;
        end else if (go) begin
            hi     <= '0;
            lo     <= is_div ? a_mag : b_mag;
            m      <= is_div ? b_mag : a_mag;
            a_r    <= a;
            cnt    <= '1;
            div_r  <= is_div;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dz_r   <= is_div && (b == '0);
        end else if (calc) begin
            if (div_r) begin
                if (!sub_diff[WIDTH]) begin
                    hi <= sub_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shifted[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= add_sum[WIDTH:1];
                lo <= {add_sum[0], lo[WIDTH-1:1]};
            end
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign last = calc && (cnt == '0);

    assign prod     = {hi, lo};
    assign prod_fix = neg_lo ? -prod : prod;

    // Divide by zero overrides the iterated values; the remainder follows the dividend's sign.
    always_comb begin
        res_lo = prod_fix[WIDTH-1:0];
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_dz = 1'b0;
        if (div_r) begin
            if (dz_r) begin
                res_lo = '1;
                res_hi = a_r;
                res_dz = 1'b1;
            end else begin
                res_lo = neg_lo ? -lo : lo;
                res_hi = neg_hi ? -hi : hi;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle basic ops plus iterative multiply/divide.
// Handshake: start is taken only when busy=0; done pulses one cycle when s/s_hi/flags are new.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [4:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_hi,
    output logic             z,
    output logic             ov,
    output logic             dz,
    output logic [1:0]       dbg_state
);

    state_t state, state_nx;

    logic             md_op, go, calc, load_basic, load_md, last;
    logic [WIDTH-1:0] sum, diff, basic_s, md_lo, md_hi;
    logic [SHW-1:0]   sh;
    logic             basic_ov, md_dz;

    assign md_op     = is_muldiv(aluc);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && md_op) state_nx = CALC;
            CALC:    if (last) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        go         = (state == IDLE) && start && md_op;
        load_basic = (state == IDLE) && start && !md_op;
        calc       = (state == CALC);
        load_md    = (state == FIX);
    end

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = a[SHW-1:0];

    always_comb begin
        basic_s  = '0;
        basic_ov = 1'b0;
        case (aluc)
            OP_ADD: begin
                basic_s  = sum;
                basic_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                basic_s  = diff;
                basic_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  basic_s = a & b;
            OP_OR:   basic_s = a | b;
            OP_XOR:  basic_s = a ^ b;
            OP_LUI:  basic_s = a << (WIDTH / 2);
            OP_SLL:  basic_s = b << sh;
            OP_SRL:  basic_s = b >> sh;
            OP_SRA:  basic_s = $signed(b) >>> sh;
            OP_SLT:  basic_s = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: basic_s = {{(WIDTH-1){1'b0}}, a < b};
            default: basic_s = '0;
        endcase
    end

    md_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .clrn      (clrn),
        .go        (go),
        .calc      (calc),
        .is_div    (aluc[1]),
        .is_signed (aluc[0]),
        .a         (a),
        .b         (b),
        .last      (last),
        .res_lo    (md_lo),
        .res_hi    (md_hi),
        .res_dz    (md_dz)
    );

    // Outputs change only on a done-producing edge and hold otherwise.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            done <= 1'b0;
            s    <= '0;
            s_hi <= '0;
            z    <= 1'b1;
            ov   <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= load_basic || load_md;
            if (load_basic) begin
                s    <= basic_s;
                s_hi <= '0;
                z    <= (basic_s == '0);
                ov   <= basic_ov;
                dz   <= 1'b0;
            end else if (load_md) begin
                s    <= md_lo;
                s_hi <= md_hi;
                z    <= (md_lo == '0);
                ov   <= 1'b0;
                dz   <= md_dz;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: driver pushes reference results with their
// expected done cycle, a negedge monitor pops and compares on every done.
module tb_alu_md;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    localparam logic [4:0] T_ADD  = 5'b00000;
    localparam logic [4:0] T_SUB  = 5'b00001;
    localparam logic [4:0] T_AND  = 5'b00010;
    localparam logic [4:0] T_OR   = 5'b00011;
    localparam logic [4:0] T_XOR  = 5'b00100;
    localparam logic [4:0] T_LUI  = 5'b00101;
    localparam logic [4:0] T_SLL  = 5'b00110;
    localparam logic [4:0] T_SRL  = 5'b00111;
    localparam logic [4:0] T_SRA  = 5'b01000;
    localparam logic [4:0] T_SLT  = 5'b01001;
    localparam logic [4:0] T_SLTU = 5'b01010;
    localparam logic [4:0] T_MULU = 5'b10000;
    localparam logic [4:0] T_MUL  = 5'b10001;
    localparam logic [4:0] T_DIVU = 5'b10010;
    localparam logic [4:0] T_DIV  = 5'b10011;

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] s_hi;
        logic         z;
        logic         ov;
        logic         dz;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         clrn, start, busy, done, z, ov, dz;
    logic [4:0]   aluc;
    logic [W-1:0] a, b, s, s_hi;
    logic [1:0]   dbg_state;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    alu_md #(.WIDTH(W)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .aluc      (aluc),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .s_hi      (s_hi),
        .z         (z),
        .ov        (ov),
        .dz        (dz),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic is_md(input logic [4:0] op);
        return (op >= T_MULU) && (op <= T_DIV);
    endfunction

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, r;
        logic [63:0] p;
        int unsigned sh;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = x % W;
        case (op)
            T_ADD:  begin r = sx + sy; e.s = x + y; e.ov = (r > SMAX) || (r < SMIN); end
            T_SUB:  begin r = sx - sy; e.s = x - y; e.ov = (r > SMAX) || (r < SMIN); end
            T_AND:  e.s = x & y;
            T_OR:   e.s = x | y;
            T_XOR:  e.s = x ^ y;
            T_LUI:  e.s = W'(64'(x) * (64'd1 << (W / 2)));
            T_SLL:  e.s = W'(64'(y) << sh);
            T_SRL:  e.s = y >> sh;
            T_SRA:  e.s = W'(sy >>> sh);
            T_SLT:  e.s = (sx < sy) ? 1 : 0;
            T_SLTU: e.s = (x < y) ? 1 : 0;
            T_MULU: begin p = 64'(x) * 64'(y); e.s = p[W-1:0]; e.s_hi = p[2*W-1:W]; end
            T_MUL:  begin p = 64'(sx * sy);    e.s = p[W-1:0]; e.s_hi = p[2*W-1:W]; end
            T_DIVU: begin
                if (y == 0) begin e.s = '1; e.s_hi = x; e.dz = 1'b1; end
                else begin e.s = x / y; e.s_hi = x % y; end
            end
            T_DIV: begin
                if (y == 0) begin e.s = '1; e.s_hi = x; e.dz = 1'b1; end
                else if (sx == SMIN && sy == -1) begin e.s = x; e.s_hi = '0; end
                else begin e.s = W'(sx / sy); e.s_hi = W'(sx % sy); end
            end
            default: e.s = '0;
        endcase
        e.z = (e.s == 0);
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (clrn && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 with s=%h expected no done (cycle %0d)", s, cyc);
            end else begin
                m_e = exp_q.pop_front();
                chk("s", s, m_e.s);
                chk("s_hi", s_hi, m_e.s_hi);
                chk("z", W'(z), W'(m_e.z));
                chk("ov", W'(ov), W'(m_e.ov));
                chk("dz", W'(dz), W'(m_e.dz));
                chk("done_cycle", cyc, m_e.cyc);
                chk("busy_in_done", W'(busy), '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
        end
        start = 1'b1;
        aluc  = op;
        a     = x;
        b     = y;
        e     = model(op, x, y);
        @(posedge clk); #1;
        e.cyc = cyc + (is_md(op) ? W + 1 : 0);
        exp_q.push_back(e);
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_s"}, s, '0);
        chk({tag, "_s_hi"}, s_hi, '0);
        chk({tag, "_z"}, W'(z), W'(1'b1));
        chk({tag, "_ov"}, W'(ov), '0);
        chk({tag, "_dz"}, W'(dz), '0);
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] op_tbl[19] = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_LUI, T_SLL, T_SRL, T_SRA,
                               T_SLT, T_SLTU, T_MULU, T_MUL, T_DIVU, T_DIV,
                               5'b01011, 5'b01111, 5'b10100, 5'b11111};

    initial begin
        int unsigned  acc1;
        int           n;
        exp_t         e;
        logic [4:0]   op;
        logic [W-1:0] x, y;

        clrn  = 1'b1;
        start = 1'b0;
        aluc  = '0;
        a     = '0;
        b     = '0;
        #2 clrn = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        clrn = 1'b1;

        // directed cases
        issue(T_ADD,  32'h7FFFFFFF, 32'h00000001);
        chk("add_busy_low", W'(busy), '0);
        issue(T_SUB,  32'd5, 32'd5);
        issue(T_SRA,  32'd4, 32'h80000000);
        issue(T_SLTU, 32'd1, 32'hFFFFFFFF);
        issue(T_SLT,  32'd1, 32'hFFFFFFFF);
        issue(T_LUI,  32'h00001234, 32'd0);
        issue(T_MUL,  32'hFFFFFFFD, 32'd5);
        issue(T_MULU, 32'hFFFFFFFF, 32'd2);
        issue(T_DIVU, 32'd100, 32'd7);
        issue(T_DIV,  32'hFFFFFFF9, 32'd2);
        issue(T_DIVU, 32'd5, 32'd0);
        issue(T_DIV,  32'h80000000, 32'hFFFFFFFF);
        issue(T_DIV,  32'hFFFFFF00, 32'd0);

        // start pulsed while busy must be ignored
        issue(T_MUL, 32'hFFFFFFFD, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; aluc = T_ADD; a = 32'd11; b = 32'd22;
        @(posedge clk); #1;
        start = 1'b0;

        // start held through the busy period is taken on the done edge
        issue(T_MULU, 32'h12345678, 32'h9ABCDEF0);
        acc1 = cyc;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; aluc = T_DIVU; a = 32'hDEADBEEF; b = 32'd0;
        e = model(T_DIVU, 32'hDEADBEEF, 32'd0);
        e.cyc = acc1 + 2 * W + 3;
        exp_q.push_back(e);
        n = 0;
        while (cyc < acc1 + W + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;

        // reset in the middle of a divide
        issue(T_DIV, 32'h7FFF0000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        issue(T_ADD, 32'd40, 32'd2);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            op = op_tbl[$urandom_range(0, 18)];
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h80000000; y = '1; end
                2: y = W'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, x, y);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d results pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, multi-cycle successor to the CPU's combinational ALU. It keeps a 1-cycle path for the basic integer ops and adds iterative signed/unsigned multiply and divide. A start/busy/done handshake lets the multi-cycle control unit stall while multiply/divide is in progress. It sits in the execute stage, fed from the register file/immediate mux, and produces a low result plus a high result (product-high or remainder).

## Interface
- WIDTH, 32: operand/result width; power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- aluc  in  5  operation code, sampled with start.
- a  in  WIDTH  operand A, sampled with start (shift amount = a[SHW-1:0]).
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while a multiply/divide is in progress.
- done  out  1  one-cycle pulse: s/s_hi/flags are valid.
- s  out  WIDTH  result: op result, product low, or quotient.
- s_hi  out  WIDTH  product high or remainder; 0 for basic ops.
- z  out  1  s == 0.
- ov  out  1  signed overflow (ADD/SUB only).
- dz  out  1  divide by zero (DIV/DIVU only).

## Operation
Basic ops (aluc[4]=0):
- 00000 ADD
- 00001 SUB
- 00010 AND
- 00011 OR
- 00100 XOR
- 00101 LUI: a << (WIDTH/2)
- 00110 SLL: b << a[SHW-1:0]
- 00111 SRL: logical right shift of b
- 01000 SRA: arithmetic right shift of b
- 01001 SLT: signed a<b gives 1, else 0
- 01010 SLTU: unsigned a<b
- Other 0xxxx codes: s=0.

Multiply/divide ops (aluc[4]=1):
- 10000 MULU, 10001 MUL (signed): {s_hi,s} = 2*WIDTH-bit product.
- 10010 DIVU, 10011 DIV (signed): s = quotient, s_hi = remainder.
- Other 1xxxx codes behave as basic ops with s=0.

Arithmetic rules:
- Multiply is iterative shift-add on magnitudes; divide is iterative restoring division on magnitudes. Each retires one bit per cycle.
- Signed ops: operands are converted to magnitude on accept. In FIX, the product/quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
- DIV of most-negative by -1: s = most-negative, s_hi = 0, no flag.
- Divide by zero: s = all ones, s_hi = a, dz = 1; full latency still applies.
- ov is computed for ADD/SUB only; ov=0 otherwise.

State machine (multiply/divide only):
- IDLE → CALC on accepted start.
- CALC runs WIDTH iterations, counted by a SHW-bit down-counter.
- CALC → FIX on the last iteration.
- FIX applies sign correction, registers the outputs, then → IDLE.

Holding and rejection:
- start with busy=1 is ignored; aluc/a/b are not sampled.
- Outputs hold their last values until the next done.

## Timing
- Accept edge E0: start=1 and busy=0.
- Basic ops: s/s_hi/z/ov registered at E0; done=1 for E0→E1; busy stays 0.
- Mul/div:
  - busy=1 from E0 to E(WIDTH+1).
  - Iterations occur at E1..E(WIDTH).
  - Results are registered at E(WIDTH+1), and done=1 for E(WIDTH+1)→E(WIDTH+2).
  - done rises WIDTH+1 cycles after E0 (33 for WIDTH=32).
- busy is 0 during the done cycle, so back-to-back starts are accepted at the done edge with no bubble.
- Reset (clrn=0), at any time including mid-CALC:
  - Immediately forces IDLE, counter=0.
  - busy=0, done=0, s=0, s_hi=0, z=1, ov=0, dz=0.
  - Partial results are discarded.
- The first start is accepted on the first rising edge after clrn deasserts.

## Structure
- Package alu_md_pkg holds:
  - the aluc encodings as localparams/enum (OP_ADD … OP_DIV);
  - the state enum {IDLE, CALC, FIX};
  - an is_muldiv() helper.
- Sub-module md_core holds the iterative datapath: accumulator/remainder register, shift register, counter, and sign-fix logic. It is parametrised by WIDTH and exposes go, is_div, is_signed, last.
- The top level holds the basic-op combinational logic, the FSM, the output registers, and the flags.

## Test plan
- ADD 7FFFFFFF+00000001 (WIDTH=32) → s=80000000, ov=1, z=0, done on E0→E1, busy never high.
- SUB 5−5 → s=0, z=1; SRA b=80000000, a=4 → s=F8000000; SLTU a=1, b=FFFFFFFF → s=1; SLT → s=0.
- MUL −3×5 → s=FFFFFFF1, s_hi=FFFFFFFF, done exactly 33 cycles after E0; MULU FFFFFFFF×2 → s=FFFFFFFE, s_hi=1.
- DIVU 100/7 → s=14, s_hi=2; DIV −7/2 → s=FFFFFFFD, s_hi=FFFFFFFF; DIVU 5/0 → s=FFFFFFFF, s_hi=5, dz=1 after full latency.
- start pulsed mid-MUL with new operands → ignored, original result returned; second start held high in the done cycle → accepted, second done 33 cycles later.
- clrn low at cycle 10 of a DIV → all outputs at reset values immediately; new ADD after release completes normally in 1 cycle.
